sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter AW, default 26, byte-address width matching the sdram controller.
REQ-003 SHALL have parameter DW, default 8, data width matching the sdram controller.
REQ-004 SHALL have port clock, input, 1, single clock shared with the sdram controller.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port req, input, NPORTS, per-port request level, held until ack.
REQ-007 SHALL have port addr, input, NPORTS*AW, packed per-port address; port i occupies [i*AW +: AW].
REQ-008 SHALL have port wdata, input, NPORTS*DW, packed per-port write data.
REQ-009 SHALL have port wr, input, NPORTS, per-port write enable (0 = read).
REQ-010 SHALL have port ack, output, NPORTS, one-cycle completion pulse per port.
REQ-011 SHALL have port rdata, output, DW, read data, valid in the ack cycle.
REQ-012 SHALL have port mem_address, output, AW, address to the sdram controller.
REQ-013 SHALL have port mem_in, output, DW, write data to the controller.
REQ-014 SHALL have port mem_we, output, 1, write enable to the controller.
REQ-015 SHALL have port mem_out, input, DW, read data from the controller.
REQ-016 SHALL have port mem_ready, input, 1, one-cycle pulse ending the access for the address held since the previous pulse.

Function
REQ-017 SHALL change mem_address, mem_in and mem_we only on a clock edge where mem_ready=1, so every controller access sees stable inputs.
REQ-018 SHALL use two states: IDLE (dummy read in flight, mem_we=0, no owner) and BUSY (access for owner port g in flight).
REQ-019 SHALL, on a mem_ready edge in BUSY, pulse ack[g] for exactly one cycle and drive rdata from mem_out registered at that edge (rdata and ack valid together).
REQ-020 SHALL, on any mem_ready edge, select the next owner from req & ~just_acked by round-robin, searching upward from (last owner + 1) mod NPORTS and wrapping.
REQ-021 SHALL, when a candidate exists, load the owner's addr/wdata/wr into mem_* and enter or stay in BUSY; otherwise it SHALL set mem_we=0, hold mem_address, and enter IDLE.
REQ-022 SHALL never grant the port acked on that same edge, so a stale req level is never served twice; that port is eligible again from the next mem_ready edge.
REQ-023 SHALL ignore req changes between mem_ready edges; the latched owner and operation are not altered.
REQ-024 SHALL deliver worst-case latency from req assertion to ack of NPORTS+1 controller accesses.
REQ-025 SHALL ignore mem_ready and produce no ack while reset=1.
REQ-026 SHALL update the round-robin pointer only on grant, never on IDLE edges.

Reset
REQ-027 SHALL on reset set state=IDLE, ack=0, rdata=0, mem_address=0, mem_in=0, mem_we=0, and pointer=NPORTS-1 so port 0 is searched first.
REQ-028 SHALL, when reset occurs mid-access, abandon that access without ack; the requester keeps req and is re-served after reset.

Structure
REQ-029 SHALL take AW/DW defaults and the state encoding (IDLE=0, BUSY=1) from shared package sdram_pkg.
REQ-030 SHALL place the round-robin search in a sub-module rr_pick (inputs: candidates, pointer; outputs: valid, index).

Verification
REQ-031 SHALL cover: port1 write addr 0xA234 data 0x55, with mem_ready every 8 cycles -> exactly one mem_we=1 access at 0xA234 with mem_in 0x55, then ack[1], then IDLE.
REQ-032 SHALL cover: all three ports requesting reads continuously, mem_out = low byte of address -> acks in order 0,1,2,0,1,2, each rdata matching its own address.
REQ-033 SHALL cover: port0 requesting back-to-back (re-asserts req the cycle after ack) while port2 requests -> grants alternate 0,2,0; port0 is never granted on its own ack edge.
REQ-034 SHALL cover: req rising between mem_ready edges -> mem_* stay constant until the next mem_ready edge; grant is visible in the cycle after that edge.
REQ-035 SHALL cover: reset asserted while BUSY for port1 -> no ack[1]; outputs match REQ-027; after release, port1 is served on the second mem_ready edge.
REQ-036 SHALL cover: the same address written (port0, 0xAA) then read (port1) -> rdata=0xAA, verified against a simple sdram behavioural model.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM front-end arbiter: default bus widths and
// the arbiter state encoding.
package sdram_pkg;
  localparam int AW_DEF = 26;
  localparam int DW_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set candidate bit above ptr, wrapping at N.
module rr_pick import sdram_pkg::*; #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index
);
  int j;

  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && cand[PW'(j)]) begin
        valid = 1'b1;
        index = PW'(j);
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// N-port round-robin arbiter in front of a single SDRAM controller; all
// controller inputs and the grant only move on mem_ready edges.
module sdram_arbiter import sdram_pkg::*; #(
  parameter int NPORTS = 3,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  input  logic [NPORTS-1:0]    wr,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_address,
  output logic [DW-1:0]        mem_in,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_out,
  input  logic                 mem_ready
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [AW-1:0]     mem_address_q, mem_address_d;
  logic [DW-1:0]     mem_in_q, mem_in_d;
  logic              mem_we_q, mem_we_d;

  logic [NPORTS-1:0] just_acked;
  logic [NPORTS-1:0] cand;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;

  // The owner finishing on this edge still has its stale req level high.
  always_comb begin
    just_acked = '0;
    if (state_q == BUSY) just_acked[owner_q] = 1'b1;
  end

  assign cand = req & ~just_acked;

  rr_pick #(.N(NPORTS), .PW(PW)) u_pick (
    .cand  (cand),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .index (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    ack_d         = '0;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    mem_we_d      = mem_we_q;
    if (mem_ready) begin
      if (state_q == BUSY) begin
        ack_d   = just_acked;
        rdata_d = mem_out;
      end
      if (pick_vld) begin
        state_d       = BUSY;
        owner_d       = pick_idx;
        ptr_d         = pick_idx;
        mem_address_d = addr[int'(pick_idx)*AW +: AW];
        mem_in_d      = wdata[int'(pick_idx)*DW +: DW];
        mem_we_d      = wr[pick_idx];
      end else begin
        // Dummy read at the held address keeps the controller cycling.
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= PW'(NPORTS - 1);
      ack_q         <= '0;
      rdata_q       <= '0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;
  assign mem_we      = mem_we_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level arbiter + SDRAM memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sdram_arbiter;
  localparam int NPORTS = 3;
  localparam int AW     = 26;
  localparam int DW     = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NPORTS-1:0]    req   = '0;
  logic [NPORTS*AW-1:0] addr  = '0;
  logic [NPORTS*DW-1:0] wdata = '0;
  logic [NPORTS-1:0]    wr    = '0;
  logic [NPORTS-1:0]    ack;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_address;
  logic [DW-1:0]        mem_in;
  logic                 mem_we;
  logic [DW-1:0]        mem_out   = '0;
  logic                 mem_ready = 1'b0;

  sdram_arbiter #(.NPORTS(NPORTS), .AW(AW), .DW(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .addr        (addr),
    .wdata       (wdata),
    .wr          (wr),
    .ack         (ack),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_we      (mem_we),
    .mem_out     (mem_out),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SDRAM contents; unwritten locations read back as the address low byte.
  logic [DW-1:0] mem [logic [AW-1:0]];
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0];
  endfunction

  // Transaction-level expectation of the arbiter.
  bit                tr_valid = 0;
  int                tr_port = 0;
  int                last_grant = NPORTS - 1;
  logic [NPORTS-1:0] m_ack = '0;
  logic [DW-1:0]     m_rdata = '0;
  logic [AW-1:0]     m_addr = '0;
  logic [DW-1:0]     m_in = '0;
  logic              m_we = 1'b0;
  int                ready_edges = 0;
  int                lat [NPORTS];
  bit                lat_en = 0;
  logic [AW-1:0]     wl_addr [$];
  logic [DW-1:0]     wl_data [$];

  initial begin
    int pick, best, d, skip;
    foreach (lat[p]) lat[p] = 0;
    forever begin
      @(posedge clock);
      m_ack = '0;
      if (reset) begin
        tr_valid = 0; last_grant = NPORTS - 1;
        m_addr = '0; m_in = '0; m_we = 1'b0; m_rdata = '0;
      end else if (mem_ready) begin
        ready_edges++;
        if (mem_we) begin
          mem[mem_address] = mem_in;
          wl_addr.push_back(mem_address);
          wl_data.push_back(mem_in);
        end
        if (lat_en) for (int p = 0; p < NPORTS; p++) if (req[p]) lat[p]++;
        skip = -1;
        if (tr_valid) begin
          m_ack[tr_port] = 1'b1;
          m_rdata = mem_out;
          skip = tr_port;
        end
        // Eligible requester closest after the last grant in rotational order.
        pick = -1; best = NPORTS;
        for (int p = 0; p < NPORTS; p++) begin
          d = (p - last_grant - 1 + 2 * NPORTS) % NPORTS;
          if (req[p] && p != skip && d < best) begin best = d; pick = p; end
        end
        if (pick >= 0) begin
          tr_valid = 1; tr_port = pick; last_grant = pick;
          m_addr = addr[pick*AW +: AW];
          m_in   = wdata[pick*DW +: DW];
          m_we   = wr[pick];
        end else begin
          tr_valid = 0; m_we = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("ack", ack, m_ack);
      if (m_ack != '0) chk("rdata", rdata, m_rdata);
      chk("mem_address", mem_address, m_addr);
      chk("mem_in", mem_in, m_in);
      chk("mem_we", mem_we, m_we);
    end
  end

  // Requester / controller driver.
  int                mr_period = 8;
  int                mr_cnt = 0;
  logic [NPORTS-1:0] hold = '0;
  bit                rand_req = 0;
  int                ack_log [$];
  logic [DW-1:0]     rd_log [$];
  int                ack_edge [$];
  logic [7:0]        t2_rd [3] = '{8'h10, 8'h21, 8'h32};

  task automatic clear_logs();
    ack_log.delete(); rd_log.delete(); ack_edge.delete();
    wl_addr.delete(); wl_data.delete();
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] dd, input logic w);
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = dd;
    wr[p]  = w;
    req[p] = 1'b1;
    lat[p] = 0;
  endtask

  task automatic cycle();
    @(negedge clock);
    for (int p = 0; p < NPORTS; p++) begin
      if (ack[p]) begin
        ack_log.push_back(p); rd_log.push_back(rdata); ack_edge.push_back(ready_edges);
        if (lat_en) chk("latency_bound", 64'(lat[p] <= NPORTS + 1), 1);
        lat[p] = 0;
        if (!hold[p]) req[p] = 1'b0;
      end
    end
    if (rand_req)
      for (int p = 0; p < NPORTS; p++)
        if (!req[p] && $urandom_range(3) == 0)
          set_port(p, AW'(32'h4000 + $urandom_range(15)), DW'($urandom), 1'($urandom_range(1)));
    if (mr_period > 0) begin
      mem_ready = (mr_cnt == mr_period - 1);
      mr_cnt = (mr_cnt + 1) % mr_period;
    end else begin
      mem_ready = ($urandom_range(2) == 0);
    end
    mem_out = rd(mem_address);
  endtask

  task automatic do_reset(input int n);
    req = '0; hold = '0; reset = 1'b1; mr_cnt = 0;
    repeat (n) cycle();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_acks(input string nm, input int n, input int max);
    for (int i = 0; i < max && ack_log.size() < n; i++) cycle();
    chk(nm, 64'(ack_log.size() >= n), 1);
  endtask

  initial begin
    int e0;
    // Write on port 1 with slow controller.
    do_reset(3);
    chk("reset_mem_address", mem_address, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_ack", ack, 0);
    chk("reset_rdata", rdata, 0);
    mr_period = 8;
    set_port(1, 26'hA234, 8'h55, 1'b1);
    repeat (40) cycle();
    chk("t1_write_count", wl_addr.size(), 1);
    if (wl_addr.size() >= 1) begin
      chk("t1_write_addr", wl_addr[0], 26'hA234);
      chk("t1_write_data", wl_data[0], 8'h55);
    end
    chk("t1_ack_count", ack_log.size(), 1);
    if (ack_log.size() >= 1) chk("t1_ack_port", ack_log[0], 1);
    chk("t1_idle_we", mem_we, 0);
    chk("t1_idle_addr_held", mem_address, 26'hA234);

    // Three continuous readers.
    do_reset(3);
    mr_period = 3; hold = '1;
    set_port(0, 26'h1010, 8'h00, 1'b0);
    set_port(1, 26'h1021, 8'h00, 1'b0);
    set_port(2, 26'h1032, 8'h00, 1'b0);
    wait_acks("t2_timeout", 6, 200);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) begin
      chk("t2_ack_order", ack_log[i], i % 3);
      chk("t2_rdata", rd_log[i], t2_rd[i % 3]);
    end

    // Port 0 back-to-back against port 2.
    do_reset(3);
    mr_period = 4; hold = 3'b101;
    set_port(0, 26'h0500, 8'h00, 1'b0);
    set_port(2, 26'h0702, 8'h00, 1'b0);
    wait_acks("t3_timeout", 5, 200);
    for (int i = 0; i < 5 && i < ack_log.size(); i++)
      chk("t3_alternate", ack_log[i], (i % 2 == 0) ? 0 : 2);

    // Request arriving between mem_ready edges.
    do_reset(3);
    mr_period = 8;
    repeat (2) cycle();
    e0 = ready_edges;
    set_port(2, 26'h0BEE, 8'h3C, 1'b1);
    for (int i = 0; i < 20 && ready_edges == e0; i++) begin
      cycle();
      if (ready_edges == e0) begin
        chk("t4_addr_stable", mem_address, 0);
        chk("t4_we_stable", mem_we, 0);
      end
    end
    chk("t4_grant_addr", mem_address, 26'h0BEE);
    chk("t4_grant_we", mem_we, 1);
    chk("t4_grant_data", mem_in, 8'h3C);

    // Reset in the middle of port 1's access.
    do_reset(3);
    mr_period = 8;
    set_port(1, 26'h2002, 8'h99, 1'b0);
    e0 = ready_edges;
    for (int i = 0; i < 20 && ready_edges == e0; i++) cycle();
    chk("t5_busy_addr", mem_address, 26'h2002);
    repeat (2) cycle();
    reset = 1'b1;
    ack_log.delete();
    repeat (10) cycle();
    chk("t5_no_ack", ack_log.size(), 0);
    chk("t5_rst_addr", mem_address, 0);
    chk("t5_rst_in", mem_in, 0);
    chk("t5_rst_we", mem_we, 0);
    chk("t5_rst_rdata", rdata, 0);
    chk("t5_rst_ack", ack, 0);
    reset = 1'b0;
    e0 = ready_edges;
    clear_logs();
    wait_acks("t5_timeout", 1, 60);
    if (ack_log.size() >= 1) begin
      chk("t5_port", ack_log[0], 1);
      chk("t5_edges", ack_edge[0] - e0, 2);
      chk("t5_rdata", rd_log[0], 8'h02);
    end

    // Write then read the same location through different ports.
    do_reset(3);
    mr_period = 4;
    set_port(0, 26'h3333, 8'hAA, 1'b1);
    wait_acks("t6_wr_timeout", 1, 100);
    set_port(1, 26'h3333, 8'h00, 1'b0);
    wait_acks("t6_rd_timeout", 2, 100);
    if (ack_log.size() >= 2) begin
      chk("t6_rd_port", ack_log[1], 1);
      chk("t6_rdata", rd_log[1], 8'hAA);
    end

    // Randomized traffic with random controller timing.
    do_reset(3);
    mr_period = 0; rand_req = 1; lat_en = 1;
    repeat (1500) cycle();
    rand_req = 0;
    repeat (60) cycle();
    lat_en = 0;
    chk("rand_no_stuck_req", req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
